// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared types for the instruction fetch stage.
//   fetch_entry_t : one prefetch FIFO entry {instruction word, word PC}
//   fetch_state_t : fetch control state
//   ENTRY_W       : flat width of fetch_entry_t, used for sub-module ports
//   pc_inc        : word-PC increment, wraps at 2^30
package rv_fetch_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:2] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FS_RESET,
    FS_RUN,
    FS_DRAIN
  } fetch_state_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [29:0] pc_inc(input logic [29:0] pc);
    return pc + 30'd1;
  endfunction

endpackage

// File: rtl/rv_fetch_fifo.sv
// rv_fetch_fifo: synchronous prefetch FIFO of fetch_entry_t.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (pointers/count only)
//   push, push_data : write one entry (ignored when full)
//   pop             : remove head entry (ignored when empty)
//   clear           : discard all entries; wins over push/pop
//   full, empty     : occupancy flags
//   count           : number of stored entries
//   head            : current head entry, read straight from the storage registers
module rv_fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  input  logic               clear,
  output logic               full,
  output logic               empty,
  output logic [CW-1:0]      count,
  output logic [ENTRY_W-1:0] head
);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   cnt;
  logic            do_push;
  logic            do_pop;

  // Pointer advance with explicit wrap so non power-of-two depths work.
  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_nxt(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_nxt(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= fetch_entry_t'(push_data);
  end

endmodule

// File: rtl/rv_fetch.sv
// rv_fetch: instruction fetch stage. Issues sequential word-address requests
// to instruction memory, buffers returned words with their PC in a prefetch
// FIFO and presents one {instr, pc, pc+1} entry per cycle to decode.
// Optional feature macro: RV_FETCH_BYPASS_EN -- forwards a response straight
// to the outputs in its arrival cycle when the FIFO is empty and decode is not
// stalled; without it every output comes from the FIFO registers.
// Ports:
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_stall                 : decode not accepting, head held
//   i_flush, i_flush_pc     : redirect to word address i_flush_pc
//   o_mem_req, o_mem_addr   : request valid / word address (held until grant)
//   i_mem_gnt               : request accepted
//   i_mem_rvalid, i_mem_rdata : in-order response
//   o_valid, o_data, o_pc, o_pc_p4 : head entry (all zero when not valid)
module rv_fetch
  import rv_fetch_pkg::*;
#(
  parameter logic [29:0] RESET_PC   = 30'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [29:0] i_flush_pc,
  output logic        o_mem_req,
  output logic [29:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic [29:0] o_pc,
  output logic [29:0] o_pc_p4
);

  localparam int            CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  fetch_state_t       st;
  logic [29:0]        fetch_pc;
  logic [CW-1:0]      outstanding;
  logic [CW-1:0]      drop_cnt;
  logic [CW-1:0]      live_cnt;
  logic [CW-1:0]      flush_left;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] head_bits_p1;
  fetch_entry_t       head_p1;
  fetch_entry_t       resp_entry_p0;
  logic               gnt;
  logic               resp_ok;
  logic               vld_p0;
  logic               vld_p1;
  logic [29:0]        resp_pc_p0;
  logic               byp;
  logic               push;
  logic               pop;

  // ---- response stage (p0): response arrives from memory ----
  assign gnt      = o_mem_req && i_mem_gnt;
  // With nothing outstanding a response is stale (e.g. left over from before reset).
  assign resp_ok  = i_mem_rvalid && (outstanding != '0);
  assign vld_p0   = resp_ok && (drop_cnt == '0) && !i_flush;
  // Responses are in order, so a live response belongs to the oldest request.
  assign resp_pc_p0    = fetch_pc - 30'(outstanding);
  assign resp_entry_p0 = '{instr: i_mem_rdata, pc: resp_pc_p0};
  assign live_cnt      = outstanding - drop_cnt;
  assign flush_left    = outstanding - CW'(resp_ok);

`ifdef RV_FETCH_BYPASS_EN
  assign byp = vld_p0 && fifo_empty && !i_stall;
`else
  assign byp = 1'b0;
`endif

  assign push    = vld_p0 && !byp && !fifo_full;
  assign head_p1 = fetch_entry_t'(head_bits_p1);
  assign vld_p1  = !fifo_empty;
  assign pop     = vld_p1 && !i_stall && !i_flush;

  // A pop in this cycle frees a slot in time for the response of a request
  // granted now, which is what sustains one instruction per cycle at depth 2.
  // Dropped responses never enter the FIFO, so only live requests count; the
  // counter cap keeps outstanding from wrapping while draining.
  always_comb begin
    o_mem_req = 1'b0;
    if (!i_reset && !i_flush && (st != FS_RESET) && (outstanding != CNT_MAX)) begin
      o_mem_req = (int'(fifo_count) + int'(live_cnt) - int'(pop)) < FIFO_DEPTH;
    end
  end
  assign o_mem_addr = fetch_pc;

  rv_fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_reset),
    .push      (push),
    .push_data (resp_entry_p0),
    .pop       (pop),
    .clear     (i_flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head_bits_p1)
  );

  // ---- control state ----
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      st          <= FS_RESET;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (i_flush) begin
      // No grant is possible in a flush cycle; a response arriving now is discarded.
      fetch_pc    <= i_flush_pc;
      outstanding <= flush_left;
      drop_cnt    <= flush_left;
      st          <= (flush_left != '0) ? FS_DRAIN : FS_RUN;
    end else begin
      if (gnt) fetch_pc <= fetch_pc + 30'd1;
      outstanding <= outstanding + CW'(gnt) - CW'(resp_ok);
      if (resp_ok && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      case (st)
        FS_RESET: st <= FS_RUN;
        FS_DRAIN: if ((drop_cnt == '0) || (resp_ok && (drop_cnt == CW'(1)))) st <= FS_RUN;
        default:  st <= st;
      endcase
    end
  end

  // ---- output stage (p1): FIFO head, or forwarded response ----
  always_comb begin
    o_valid = 1'b0;
    o_data  = '0;
    o_pc    = '0;
    o_pc_p4 = '0;
    if (byp) begin
      o_valid = 1'b1;
      o_data  = i_mem_rdata;
      o_pc    = resp_pc_p0;
    end else if (vld_p1) begin
      o_valid = 1'b1;
      o_data  = head_p1.instr;
      o_pc    = head_p1.pc;
    end
    if (o_valid) o_pc_p4 = pc_inc(o_pc);
  end

endmodule
